register_scoreboard: RTL and testbench

Pipeline hazard scoreboard for the 16-bit 5-stage core. It tracks the destination register of every in-flight register-writing instruction in the EX, MEM and WB stages, and produces the per-register `register_invalid` codes that `controller` uses for stall and forwarding decisions. It advances and clears its stage tags using the same enable and flush strobes that drive the ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/register_scoreboard_if.sv | 29 ++
 rtl/register_scoreboard.sv | 94 +++++++++
 tb/tb_register_scoreboard.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/register_scoreboard_if.sv
// Hazard scoreboard interface: ID-stage write info, pipeline enable/flush
// strobes in, per-register hazard codes and drain status out.
interface register_scoreboard_if;
    logic                regwrite_cur;
    logic [2:0]          regwrite_adr_id;
    logic                from_main_mem_id;
    logic                en_idex;
    logic                flush_idex;
    logic                en_exmem;
    logic                flush_exmem;
    logic                en_memwb;
    logic                flush_memwb;
    logic [7:0][2:0]     register_invalid;
    logic                pipe_empty;

    // Controller / pipeline side
    modport master (
        output regwrite_cur, regwrite_adr_id, from_main_mem_id,
        output en_idex, flush_idex, en_exmem, flush_exmem, en_memwb, flush_memwb,
        input  register_invalid, pipe_empty
    );

    // Scoreboard side
    modport slave (
        input  regwrite_cur, regwrite_adr_id, from_main_mem_id,
        input  en_idex, flush_idex, en_exmem, flush_exmem, en_memwb, flush_memwb,
        output register_invalid, pipe_empty
    );
endinterface

// File: rtl/register_scoreboard.sv
// Pipeline hazard scoreboard for the 16-bit 5-stage core.
// Tracks the destination register of in-flight writes in EX, MEM and WB and
// decodes a per-register hazard code for the controller.
// Optional feature macro: SCOREBOARD_WB_BYPASS_EN -- when defined, a WB-only
// match reports 0 (write-through register file); otherwise it reports 1.
module register_scoreboard (
    input  logic                  clk,
    input  logic                  reset_n,
    register_scoreboard_if.slave  sb
);
    typedef struct packed {
        logic       v;
        logic [2:0] dst;
        logic       ld;
    } tag_t;

    typedef struct packed {
        logic       v;
        logic [2:0] dst;
    } wb_tag_t;

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_LD_STALL = 3'd1;
    localparam logic [2:0] CODE_FWD_EX  = 3'd2;
    localparam logic [2:0] CODE_FWD_MEM = 3'd3;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam logic [2:0] CODE_WB      = 3'd0;
`else
    localparam logic [2:0] CODE_WB      = 3'd1;
`endif

    tag_t            r_ex;
    tag_t            r_mem;
    wb_tag_t         r_wb;
    logic [7:0][2:0] w_register_invalid;
    logic            w_pipe_empty;

    // EX tag: flush inserts a bubble, enable captures the ID instruction.
    // NOTE: sequential state uses non-blocking assignments so every tag
    // samples the pre-edge value of the stage before it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex <= '0;
        end else if (sb.flush_idex) begin
            r_ex.v <= 1'b0;
        end else if (sb.en_idex) begin
            r_ex <= '{v: sb.regwrite_cur, dst: sb.regwrite_adr_id, ld: sb.from_main_mem_id};
        end
    end

    // MEM tag: follows the EX tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem <= '0;
        end else if (sb.flush_exmem) begin
            r_mem.v <= 1'b0;
        end else if (sb.en_exmem) begin
            r_mem <= r_ex;
        end
    end

    // WB tag: follows the MEM tag; the load flag is irrelevant here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wb <= '0;
        end else if (sb.flush_memwb) begin
            r_wb.v <= 1'b0;
        end else if (sb.en_memwb) begin
            r_wb <= '{v: r_mem.v, dst: r_mem.dst};
        end
    end

    // Decode per-register codes from registered tags only, youngest match first.
    // NOTE: outputs get a default before the loop so no path leaves them
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_register_invalid = '0;
        for (int r = 0; r < 8; r++) begin
            if (r_ex.v && (r_ex.dst == 3'(r))) begin
                w_register_invalid[r] = r_ex.ld ? CODE_LD_STALL : CODE_FWD_EX;
            end else if (r_mem.v && (r_mem.dst == 3'(r))) begin
                w_register_invalid[r] = CODE_FWD_MEM;
            end else if (r_wb.v && (r_wb.dst == 3'(r))) begin
                w_register_invalid[r] = CODE_WB;
            end else begin
                w_register_invalid[r] = CODE_NONE;
            end
        end
    end

    assign w_pipe_empty         = !(r_ex.v || r_mem.v || r_wb.v);
    assign sb.register_invalid  = w_register_invalid;
    assign sb.pipe_empty        = w_pipe_empty;
endmodule

// File: tb/tb_register_scoreboard.sv
// Self-checking bench for register_scoreboard. Stimulus pushes expected
// codes into a queue tagged with the cycle they apply to; a monitor samples
// the outputs mid-cycle (and on reset assertion) and pops matching entries.
module tb_register_scoreboard;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam logic [2:0] WB_CODE = 3'd0;
`else
    localparam logic [2:0] WB_CODE = 3'd1;
`endif
    localparam int KIND_CODE = 0;
    localparam int KIND_EMPTY = 1;
    localparam int KIND_ALLZERO = 2;

    typedef struct {
        int         cyc;
        int         kind;
        int         r;
        logic [2:0] code;
        logic       emp;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    register_scoreboard_if sb_if ();

    register_scoreboard dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sb      (sb_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_entry(input exp_t e);
        case (e.kind)
            KIND_CODE:  check(e.name, 32'(sb_if.register_invalid[e.r]), 32'(e.code));
            KIND_EMPTY: check(e.name, 32'(sb_if.pipe_empty), 32'(e.emp));
            default: begin
                check({e.name, "_codes"}, 32'(sb_if.register_invalid), 32'd0);
                check({e.name, "_empty"}, 32'(sb_if.pipe_empty), 32'd1);
            end
        endcase
    endtask

    // Monitor: wakes mid-cycle and on reset assertion, checks due entries.
    always begin
        @(negedge clk or negedge reset_n);
        #1;
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
                compare_entry(exp_q[i]);
                exp_q.delete(i);
            end else if (exp_q[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: never sampled (due cycle %0d, now %0d)", exp_q[i].name, exp_q[i].cyc, cyc);
                exp_q.delete(i);
            end
        end
    end

    task automatic exp_code(input int r, input logic [2:0] code, input string name);
        exp_q.push_back('{cyc: cyc, kind: KIND_CODE, r: r, code: code, emp: 1'b0, name: name});
    endtask

    task automatic exp_empty(input logic e, input string name);
        exp_q.push_back('{cyc: cyc, kind: KIND_EMPTY, r: 0, code: 3'd0, emp: e, name: name});
    endtask

    task automatic exp_all_zero(input string name);
        exp_q.push_back('{cyc: cyc, kind: KIND_ALLZERO, r: 0, code: 3'd0, emp: 1'b1, name: name});
    endtask

    // Drive one cycle of inputs; en/fl bits are {idex, exmem, memwb}.
    task automatic drive(input logic rw, input logic [2:0] adr, input logic ld,
                         input logic [2:0] en, input logic [2:0] fl);
        sb_if.regwrite_cur     = rw;
        sb_if.regwrite_adr_id  = adr;
        sb_if.from_main_mem_id = ld;
        {sb_if.en_idex, sb_if.en_exmem, sb_if.en_memwb} = en;
        {sb_if.flush_idex, sb_if.flush_exmem, sb_if.flush_memwb} = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 1'b0, 3'b111, 3'b000);
    endtask

    initial begin
        sb_if.regwrite_cur = 1'b0;
        sb_if.regwrite_adr_id = 3'd0;
        sb_if.from_main_mem_id = 1'b0;
        {sb_if.en_idex, sb_if.en_exmem, sb_if.en_memwb} = 3'b111;
        {sb_if.flush_idex, sb_if.flush_exmem, sb_if.flush_memwb} = 3'b000;

        // Reset state
        drive(1'b1, 3'd3, 1'b0, 3'b111, 3'b000);
        exp_all_zero("reset_state");
        idle();
        reset_n = 1'b1;
        idle();
        exp_empty(1'b1, "post_reset_empty");

        // ALU write r1: 2 -> 3 -> WB -> 0
        drive(1'b1, 3'd1, 1'b0, 3'b111, 3'b000);
        exp_code(1, 3'd2, "alu_ex"); exp_empty(1'b0, "alu_busy");
        idle(); exp_code(1, 3'd3, "alu_mem");
        idle(); exp_code(1, WB_CODE, "alu_wb");
        idle(); exp_code(1, 3'd0, "alu_done"); exp_empty(1'b1, "alu_empty");

        // Load r2: 1 -> 3 -> WB -> 0
        drive(1'b1, 3'd2, 1'b1, 3'b111, 3'b000);
        exp_code(2, 3'd1, "ld_ex");
        idle(); exp_code(2, 3'd3, "ld_mem");
        idle(); exp_code(2, WB_CODE, "ld_wb");
        idle(); exp_code(2, 3'd0, "ld_done");

        // Youngest priority: ADD r3 then LD r3
        drive(1'b1, 3'd3, 1'b0, 3'b111, 3'b000); exp_code(3, 3'd2, "young_add");
        drive(1'b1, 3'd3, 1'b1, 3'b111, 3'b000); exp_code(3, 3'd1, "young_ld_over_add");
        idle(); exp_code(3, 3'd3, "young_mem");
        idle(); exp_code(3, WB_CODE, "young_wb");
        idle(); exp_code(3, 3'd0, "young_done"); exp_empty(1'b1, "young_empty");

        // Hold: all enables and flushes low keep the tag in place
        drive(1'b1, 3'd2, 1'b0, 3'b111, 3'b000); exp_code(2, 3'd2, "hold_issue");
        drive(1'b1, 3'd6, 1'b0, 3'b000, 3'b000);
        exp_code(2, 3'd2, "hold_keep"); exp_code(6, 3'd0, "hold_no_load");
        idle(); exp_code(2, 3'd3, "hold_resume");
        idle(); idle(); exp_empty(1'b1, "hold_empty");

        // Branch miss: r4, r5 issued; flush EX/MEM while r6 sits in ID
        drive(1'b1, 3'd4, 1'b0, 3'b111, 3'b000); exp_code(4, 3'd2, "br_r4_ex");
        drive(1'b1, 3'd5, 1'b0, 3'b111, 3'b000); exp_code(5, 3'd2, "br_r5_ex"); exp_code(4, 3'd3, "br_r4_mem");
        drive(1'b1, 3'd6, 1'b0, 3'b111, 3'b110);
        exp_code(6, 3'd0, "br_r6_flushed"); exp_code(5, 3'd0, "br_r5_flushed");
        exp_code(4, WB_CODE, "br_r4_wb"); exp_empty(1'b0, "br_wb_busy");
        idle(); exp_code(4, 3'd0, "br_r4_done"); exp_empty(1'b1, "br_empty");

        // Stall bubble: LD r1 in EX, bubble enters while r7 is presented
        drive(1'b1, 3'd1, 1'b1, 3'b111, 3'b000); exp_code(1, 3'd1, "stall_ld_ex");
        drive(1'b1, 3'd7, 1'b0, 3'b111, 3'b100);
        exp_code(1, 3'd3, "stall_ld_mem"); exp_code(7, 3'd0, "stall_bubble");
        idle(); exp_code(1, WB_CODE, "stall_ld_wb"); exp_code(7, 3'd0, "stall_r7_absent");
        idle(); exp_empty(1'b1, "stall_empty");

        // Flush beats enable on MEM/WB
        drive(1'b1, 3'd2, 1'b0, 3'b111, 3'b000);
        idle(); exp_code(2, 3'd3, "fl_mem");
        drive(1'b0, 3'd0, 1'b0, 3'b111, 3'b001);
        exp_code(2, 3'd0, "fl_memwb_beats_en"); exp_empty(1'b1, "fl_empty");

        // Async reset with three tags valid
        drive(1'b1, 3'd1, 1'b0, 3'b111, 3'b000);
        drive(1'b1, 3'd2, 1'b0, 3'b111, 3'b000);
        drive(1'b1, 3'd3, 1'b0, 3'b111, 3'b000);
        exp_code(3, 3'd2, "ar_r3_ex"); exp_code(2, 3'd3, "ar_r2_mem");
        exp_code(1, WB_CODE, "ar_r1_wb"); exp_empty(1'b0, "ar_busy");
        @(negedge clk);
        #3;
        exp_all_zero("ar_immediate");
        reset_n = 1'b0;
        @(posedge clk); #1; exp_all_zero("ar_held1");
        @(posedge clk); #1; exp_all_zero("ar_held2");
        reset_n = 1'b1;
        drive(1'b1, 3'd5, 1'b0, 3'b111, 3'b000);
        exp_code(5, 3'd2, "ar_first_issue"); exp_code(3, 3'd0, "ar_r3_gone");
        idle(); idle(); idle(); exp_empty(1'b1, "ar_final_empty");

        repeat (2) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: %0d expectations pending, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
